// File: rtl/matrix_random_fetch_pkg.sv
// Shared definitions for the matrix random-fetch block.
// Holds the state encodings for the fetch FSM and the UART byte sender, the
// ASCII constants used in the printed output, the LFSR tap mask, the default
// largest matrix dimension, and the decimal formatting helpers.
package matrix_random_fetch_pkg;

  localparam int MAX_SIZE = 5;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;

  // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REDUCE,
    ST_SEND,
    ST_SEND_WAIT,
    ST_SET_ADDR,
    ST_WAIT1,
    ST_WAIT2,
    ST_SAMPLE,
    ST_FAIL,
    ST_DONE
  } fetch_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_HI,
    TX_WAIT_LO,
    TX_GAP
  } tx_state_t;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } dec_t;

  // Up to five bytes of output text; bytes[0] goes out first.
  typedef struct packed {
    logic [4:0][7:0] bytes;
    logic [2:0]      len;
  } line_t;

  function automatic dec_t to_dec(input logic [7:0] v);
    dec_t d;
    d.h = 4'(v / 8'd100);
    d.t = 4'((v % 8'd100) / 8'd10);
    d.o = 4'(v % 8'd10);
    return d;
  endfunction

  // Optional prefix, the value in decimal without leading zeros, then suffix.
  function automatic line_t fmt_line(input logic has_pre, input logic [7:0] pre,
                                     input logic [7:0] v, input logic [7:0] suf);
    line_t      l;
    dec_t       d;
    logic [2:0] n;
    l = '0;
    d = to_dec(v);
    n = 3'd0;
    if (has_pre) begin
      l.bytes[n] = pre;
      n = n + 3'd1;
    end
    if (d.h != 4'd0) begin
      l.bytes[n] = ASCII_0 + {4'd0, d.h};
      n = n + 3'd1;
    end
    if (d.h != 4'd0 || d.t != 4'd0) begin
      l.bytes[n] = ASCII_0 + {4'd0, d.t};
      n = n + 3'd1;
    end
    l.bytes[n] = ASCII_0 + {4'd0, d.o};
    n = n + 3'd1;
    l.bytes[n] = suf;
    n = n + 3'd1;
    l.len = n;
    return l;
  endfunction

endpackage

// File: rtl/matrix_random_fetch_if.sv
// Bus bundle for matrix_random_fetch: start/status handshake, storage read
// port and UART transmitter port.
//   master : the fetch block (drives status, storage address, UART request)
//   slave  : the surrounding system (drives start/scale, read data, UART busy)
interface matrix_random_fetch_if #(
  parameter int CNT_WIDTH  = 5,
  parameter int DATA_WIDTH = 8
) ();
  logic                  start_req;
  logic [2:0]            in_r;
  logic [2:0]            in_c;
  logic [CNT_WIDTH-1:0]  in_cnt;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CNT_WIDTH-1:0]  sel_idx;
  logic [2:0]            st_rd_r;
  logic [2:0]            st_rd_c;
  logic [CNT_WIDTH-1:0]  st_rd_idx;
  logic [2:0]            st_rd_i;
  logic [2:0]            st_rd_j;
  logic [DATA_WIDTH-1:0] st_rd_data;
  logic                  uart_tx_busy;
  logic                  uart_tx_start;
  logic [7:0]            uart_tx_data;

  modport master (
    input  start_req, in_r, in_c, in_cnt, st_rd_data, uart_tx_busy,
    output busy, done, err, sel_idx, st_rd_r, st_rd_c, st_rd_idx, st_rd_i,
           st_rd_j, uart_tx_start, uart_tx_data
  );

  modport slave (
    output start_req, in_r, in_c, in_cnt, st_rd_data, uart_tx_busy,
    input  busy, done, err, sel_idx, st_rd_r, st_rd_c, st_rd_idx, st_rd_i,
           st_rd_j, uart_tx_start, uart_tx_data
  );
endinterface

// File: rtl/matrix_random_fetch_uart_byte_sender.sv
// One-byte handshake with the shared UART transmitter.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   send, send_byte      request (one cycle) and byte to transmit
//   uart_tx_busy         transmitter busy
//   uart_tx_start        send request, held until the transmitter finishes
//   uart_tx_data         byte, stable while uart_tx_start is high
//   sent                 one-cycle pulse after the gap cycle
module uart_byte_sender
  import matrix_random_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] send_byte,
  input  logic       uart_tx_busy,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  output logic       sent
);

  tx_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= TX_IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'd0;
      sent          <= 1'b0;
    end else begin
      sent <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          if (send) begin
            uart_tx_data  <= send_byte;
            uart_tx_start <= 1'b1;
            state         <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (uart_tx_busy) state <= TX_WAIT_LO;
        end
        TX_WAIT_LO: begin
          if (!uart_tx_busy) begin
            uart_tx_start <= 1'b0;
            state         <= TX_GAP;
          end
        end
        TX_GAP: begin
          sent  <= 1'b1;
          state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matrix_random_fetch.sv
// Picks one stored matrix of the selected scale pseudo-randomly, reads its
// elements from storage and prints it as decimal text over the UART.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          matrix_random_fetch_if.master: start_req/in_r/in_c/in_cnt in,
//                busy/done/err/sel_idx out, storage read address out and data
//                in, UART start/data out and busy in
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | wait for start_req, latch scale, count and LFSR
// ST_CHECK     | validate scale and count
// ST_REDUCE    | repeated subtraction: value mod cnt, then build header line
// ST_SEND      | hand the next byte of line_q to the byte sender
// ST_SEND_WAIT | wait for the byte sender, then next byte or nxt state
// ST_SET_ADDR  | storage address valid (loaded on entry)
// ST_WAIT1/2   | storage read latency
// ST_SAMPLE    | capture element, build its text line, advance i/j
// ST_FAIL      | build the "E\n" line
// ST_DONE      | drop busy, pulse done, report err
module matrix_random_fetch #(
  parameter int         MAX_SIZE   = matrix_random_fetch_pkg::MAX_SIZE,
  parameter int         CNT_WIDTH  = 5,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_random_fetch_if.master bus
);
  import matrix_random_fetch_pkg::*;

  fetch_state_t          state, nxt;
  logic [7:0]            lfsr;
  logic [7:0]            val;
  logic [2:0]            r_q, c_q, i_q, j_q, pos;
  logic [CNT_WIDTH-1:0]  cnt_q;
  line_t                 line_q;
  logic                  fail_q;
  logic                  busy_q, done_q, err_q;
  logic [CNT_WIDTH-1:0]  sel_q;
  logic [2:0]            rd_r, rd_c, rd_i, rd_j;
  logic [CNT_WIDTH-1:0]  rd_idx;
  logic                  send;
  logic [7:0]            send_byte;
  logic                  sent;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  bad_input;
  logic                  last_col;

  assign rd_data   = bus.st_rd_data;
  assign bad_input = (r_q == 3'd0) || (r_q > 3'(MAX_SIZE)) ||
                     (c_q == 3'd0) || (c_q > 3'(MAX_SIZE)) ||
                     (cnt_q == '0);
  assign last_col  = (j_q == c_q - 3'd1);

  // Free-running; a start simply snapshots whatever value it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      nxt       <= ST_IDLE;
      val       <= 8'd0;
      r_q       <= 3'd0;
      c_q       <= 3'd0;
      i_q       <= 3'd0;
      j_q       <= 3'd0;
      pos       <= 3'd0;
      cnt_q     <= '0;
      line_q    <= '0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
      rd_r      <= 3'd1;
      rd_c      <= 3'd1;
      rd_i      <= 3'd0;
      rd_j      <= 3'd0;
      rd_idx    <= '0;
      send      <= 1'b0;
      send_byte <= 8'd0;
    end else begin
      send   <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // done_q high means this is the completion cycle: starts are dropped
          if (bus.start_req && !done_q) begin
            r_q    <= bus.in_r;
            c_q    <= bus.in_c;
            cnt_q  <= bus.in_cnt;
            val    <= lfsr;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            fail_q <= 1'b0;
            sel_q  <= '0;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: state <= bad_input ? ST_FAIL : ST_REDUCE;
        ST_REDUCE: begin
          if (val >= 8'(cnt_q)) begin
            val <= val - 8'(cnt_q);
          end else begin
            sel_q  <= CNT_WIDTH'(val + 8'd1);
            line_q <= fmt_line(1'b1, ASCII_HASH, val + 8'd1, ASCII_LF);
            pos    <= 3'd0;
            i_q    <= 3'd0;
            j_q    <= 3'd0;
            nxt    <= ST_SET_ADDR;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          send      <= 1'b1;
          send_byte <= line_q.bytes[pos];
          state     <= ST_SEND_WAIT;
        end
        ST_SEND_WAIT: begin
          if (sent) begin
            if (pos == line_q.len - 3'd1) begin
              state <= nxt;
              // Address is loaded on entry so it is already valid in SET_ADDR.
              if (nxt == ST_SET_ADDR) begin
                rd_r   <= r_q;
                rd_c   <= c_q;
                rd_idx <= sel_q;
                rd_i   <= i_q;
                rd_j   <= j_q;
              end
            end else begin
              pos   <= pos + 3'd1;
              state <= ST_SEND;
            end
          end
        end
        ST_SET_ADDR: state <= ST_WAIT1;
        ST_WAIT1:    state <= ST_WAIT2;
        ST_WAIT2:    state <= ST_SAMPLE;
        ST_SAMPLE: begin
          line_q <= fmt_line(1'b0, ASCII_0, 8'(rd_data), last_col ? ASCII_LF : ASCII_SP);
          pos    <= 3'd0;
          state  <= ST_SEND;
          if (last_col) begin
            j_q <= 3'd0;
            i_q <= i_q + 3'd1;
            nxt <= (i_q == r_q - 3'd1) ? ST_DONE : ST_SET_ADDR;
          end else begin
            j_q <= j_q + 3'd1;
            nxt <= ST_SET_ADDR;
          end
        end
        ST_FAIL: begin
          line_q <= {24'd0, ASCII_LF, ASCII_E, 3'd2};
          pos    <= 3'd0;
          fail_q <= 1'b1;
          nxt    <= ST_DONE;
          state  <= ST_SEND;
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q  <= fail_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_sender u_sender (
    .clk           (clk),
    .rst_n         (rst_n),
    .send          (send),
    .send_byte     (send_byte),
    .uart_tx_busy  (bus.uart_tx_busy),
    .uart_tx_start (bus.uart_tx_start),
    .uart_tx_data  (bus.uart_tx_data),
    .sent          (sent)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sel_idx   = sel_q;
  assign bus.st_rd_r   = rd_r;
  assign bus.st_rd_c   = rd_c;
  assign bus.st_rd_idx = rd_idx;
  assign bus.st_rd_i   = rd_i;
  assign bus.st_rd_j   = rd_j;

endmodule

// File: tb/tb_matrix_random_fetch.sv
module tb_matrix_random_fetch;

  logic clk;
  logic rst_n;

  matrix_random_fetch_if #(.CNT_WIDTH(5), .DATA_WIDTH(8)) ifc ();

  matrix_random_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int busy_len = 2;
  int stab_err = 0;
  int rst_cnt = 0;
  logic [7:0] rx_q[$];

  // Behavioural storage: 2-cycle read pipeline over a bench-owned array.
  logic [7:0] mem [0:31][0:7][0:7];
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    p1 <= mem[ifc.st_rd_idx][ifc.st_rd_i][ifc.st_rd_j];
    p2 <= p1;
  end
  assign ifc.st_rd_data = p2;

  // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, stages 8,6,5,4 fed back.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge rst_n) rst_cnt = rst_cnt + 1;

  // Behavioural UART transmitter: accept a byte, stay busy busy_len cycles.
  initial begin
    logic [7:0] b;
    int ep;
    ifc.uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.uart_tx_start) begin
        b  = ifc.uart_tx_data;
        ep = rst_cnt;
        rx_q.push_back(b);
        @(negedge clk);
        ifc.uart_tx_busy = 1'b1;
        for (int k = 0; k < busy_len; k++) begin
          @(negedge clk);
          if (ep == rst_cnt && (!ifc.uart_tx_start || ifc.uart_tx_data != b))
            stab_err = stab_err + 1;
        end
        ifc.uart_tx_busy = 1'b0;
        for (int k = 0; k < 8 && ifc.uart_tx_start; k++) @(negedge clk);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [2:0] r, c, input logic [4:0] cnt);
    return (r == 0) || (r > 5) || (c == 0) || (c > 5) || (cnt == 0);
  endfunction

  task automatic fill_mem();
    for (int x = 0; x < 32; x++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          case ($urandom_range(0, 3))
            0:       mem[x][i][j] = 8'd0;
            1:       mem[x][i][j] = 8'd255;
            default: mem[x][i][j] = 8'($urandom_range(0, 255));
          endcase
  endtask

  function automatic logic [16:0] addr_now();
    return {ifc.st_rd_r, ifc.st_rd_c, ifc.st_rd_idx, ifc.st_rd_i, ifc.st_rd_j};
  endfunction

  task automatic drive_start(input logic [2:0] r, c, input logic [4:0] cnt);
    ifc.in_r = r;
    ifc.in_c = c;
    ifc.in_cnt = cnt;
    ifc.start_req = 1'b1;
    @(negedge clk);
    ifc.start_req = 1'b0;
    ifc.in_r = 3'($urandom);
    ifc.in_c = 3'($urandom);
    ifc.in_cnt = 5'($urandom);
  endtask

  task automatic run_one(input string tag, input logic [2:0] r, c, input logic [4:0] cnt,
                         input bit exp_err, input bit ghost);
    logic [7:0]  l0;
    logic [16:0] addr0;
    int          eidx;
    int          bad;
    string       s;
    bit          seen;
    @(negedge clk);
    rx_q.delete();
    stab_err = 0;
    addr0 = addr_now();
    l0 = m_lfsr;
    drive_start(r, c, cnt);
    check({tag, "_busy_rise"}, ifc.busy, 1);
    eidx = exp_err ? 0 : int'(l0 % cnt) + 1;
    if (exp_err) s = "E\n";
    else begin
      s = $sformatf("#%0d\n", eidx);
      for (int i = 0; i < int'(r); i++)
        for (int j = 0; j < int'(c); j++)
          if (j == int'(c) - 1) s = {s, $sformatf("%0d\n", mem[eidx][i][j])};
          else                  s = {s, $sformatf("%0d ", mem[eidx][i][j])};
    end
    seen = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      if (ifc.done) seen = 1;
      else begin
        if (ghost && k == 6) begin
          ifc.in_r = 3'd1; ifc.in_c = 3'd1; ifc.in_cnt = 5'd1;
          ifc.start_req = 1'b1;
        end
        @(negedge clk);
        ifc.start_req = 1'b0;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (!seen) return;
    check({tag, "_busy_fall"}, ifc.busy, 0);
    check({tag, "_err"}, ifc.err, exp_err);
    if (!exp_err) begin
      check({tag, "_sel_idx"}, ifc.sel_idx, eidx);
      check({tag, "_last_addr"}, addr_now(),
            {r, c, 5'(eidx), r - 3'd1, c - 3'd1});
    end else begin
      check({tag, "_no_reads"}, addr_now(), addr0);
    end
    bad = -1;
    for (int k = 0; k < s.len() || k < rx_q.size(); k++)
      if (bad < 0 && (k >= s.len() || k >= rx_q.size() || rx_q[k] != s[k])) bad = k;
    if (bad >= 0)
      $display("stream %s: first difference at byte %0d (got %0d bytes, want %0d)",
               tag, bad, rx_q.size(), s.len());
    check({tag, "_stream_first_bad"}, 64'(bad), 64'(-1));
    check({tag, "_tx_stable"}, stab_err, 0);
    if (ghost) ifc.start_req = 1'b1;
    @(negedge clk);
    ifc.start_req = 1'b0;
    check({tag, "_done_pulse"}, ifc.done, 0);
    if (ghost) begin
      repeat (4) @(negedge clk);
      check({tag, "_ghost_busy"}, ifc.busy, 0);
      check({tag, "_ghost_bytes"}, rx_q.size(), s.len());
    end
  endtask

  typedef struct {
    logic [2:0] r;
    logic [2:0] c;
    logic [4:0] cnt;
    bit         fixed;
    bit         ghost;
    bit         exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [2:0] rr, cc;
    logic [4:0] nn;
    tbl[0] = '{3'd2, 3'd2, 5'd1,  1'b1, 1'b0, 1'b0};
    tbl[1] = '{3'd3, 3'd1, 5'd3,  1'b0, 1'b1, 1'b0};
    tbl[2] = '{3'd2, 3'd2, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[3] = '{3'd6, 3'd2, 5'd3,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{3'd2, 3'd0, 5'd3,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{3'd0, 3'd3, 5'd2,  1'b0, 1'b0, 1'b1};
    tbl[6] = '{3'd5, 3'd5, 5'd31, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'd1, 3'd1, 5'd1,  1'b0, 1'b0, 1'b0};
    tbl[8] = '{3'd4, 3'd3, 5'd7,  1'b0, 1'b0, 1'b0};
    tbl[9] = '{3'd7, 3'd7, 5'd4,  1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    ifc.start_req = 1'b0;
    ifc.in_r = 3'd0;
    ifc.in_c = 3'd0;
    ifc.in_cnt = 5'd0;
    fill_mem();
    repeat (3) @(negedge clk);
    check("reset_status", {ifc.busy, ifc.done, ifc.err, ifc.sel_idx}, 8'd0);
    check("reset_addr", addr_now(), {3'd1, 3'd1, 5'd0, 3'd0, 3'd0});
    check("reset_uart", {ifc.uart_tx_start, ifc.uart_tx_data}, 9'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      fill_mem();
      if (tbl[t].fixed) begin
        mem[1][0][0] = 8'd1;
        mem[1][0][1] = 8'd20;
        mem[1][1][0] = 8'd0;
        mem[1][1][1] = 8'd255;
      end
      run_one($sformatf("vec%0d", t), tbl[t].r, tbl[t].c, tbl[t].cnt,
              tbl[t].exp_err, tbl[t].ghost);
    end

    for (int t = 0; t < 8; t++) begin
      fill_mem();
      rr = 3'($urandom_range(0, 6));
      cc = 3'($urandom_range(0, 6));
      nn = 5'($urandom_range(0, 31));
      run_one($sformatf("rnd%0d", t), rr, cc, nn, model_err(rr, cc, nn), 1'b0);
    end

    busy_len = 50;
    run_one("stall", 3'd1, 3'd2, 5'd2, 1'b0, 1'b0);
    busy_len = 2;

    begin
      int k;
      @(negedge clk);
      rx_q.delete();
      drive_start(3'd3, 3'd3, 5'd2);
      for (k = 0; k < 5000 && rx_q.size() < 5; k++) @(negedge clk);
      check("mid_reached", rx_q.size() >= 5, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_status", {ifc.busy, ifc.done, ifc.err, ifc.sel_idx}, 8'd0);
      check("mid_rst_addr", addr_now(), {3'd1, 3'd1, 5'd0, 3'd0, 3'd0});
      check("mid_rst_uart", {ifc.uart_tx_start, ifc.uart_tx_data}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (k = 0; k < 200 && ifc.uart_tx_busy; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      run_one("after_rst", 3'd3, 3'd3, 5'd2, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
